seg7_scan_counter: RTL

- Parametrised successor to the team's single-digit 7-segment counter.
- N-digit BCD up/down counter with prescaler, parallel load and wrap flag.
- Time-multiplexed display driver: one shared segment bus and per-digit select lines.
- Sits inside the tt_um top between ui_in/uio_in and uo_out/uio_out. Segments go on uo_out[6:0], dp on uo_out[7], digit selects on uio_out.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/bcd_digit.sv | 42 ++++
 rtl/seg7_scan_counter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the 7-segment decode table for the scanned BCD counter.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  // Segment patterns for digits 0..9, bit 0 = segment a.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_decode(bcd_t d);
    logic [6:0] s;
    if (d > 4'd9) begin
      s = 7'b0;
    end else begin
      s = SEG_LUT[d];
    end
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: load, increment or decrement with carry/borrow out.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t d,
  output bcd_t q,
  output logic carry_out,
  output logic borrow_out
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (d > 4'd9) ? 4'd0 : d;
    end else if (inc) begin
      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else if (ena) begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign carry_out  = inc & ~load & (q_q == 4'd9);
  assign borrow_out = dec & ~load & (q_q == 4'd0);

endmodule

// File: rtl/seg7_scan_counter.sv
// N-digit BCD up/down counter with prescaler and a time-multiplexed 7-segment driver.
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned PRESCALE    = 1000000,
  parameter int unsigned SCAN_DIV    = 1000,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          SEL_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  count_en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  always_comb begin
    tick  = count_en && (pre_q == PRE_LAST);
    pre_d = pre_q;
    if (load) begin
      pre_d = '0;
    end else if (count_en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  // Ripple chain: digit 0 is fed by the tick, each higher digit by the one below.
  logic [DIGITS:0] carry, borrow;
  bcd_t            digit_q [DIGITS];

  assign carry[0]  = tick & up_dn & ~load;
  assign borrow[0] = tick & ~up_dn & ~load;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .inc       (carry[i]),
      .dec       (borrow[i]),
      .load      (load),
      .d         (load_val[4*i +: 4]),
      .q         (digit_q[i]),
      .carry_out (carry[i+1]),
      .borrow_out(borrow[i+1])
    );
  end

  always_comb begin
    value = '0;
    for (int i = 0; i < DIGITS; i++) begin
      value[4*i +: 4] = digit_q[i];
    end
  end

  // wrap is a pulse, so it always reloads instead of holding with ena.
  logic wrap_q, wrap_d;
  assign wrap_d = ena & (carry[DIGITS] | borrow[DIGITS]);
  assign wrap   = wrap_q & ena;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0] scan_idx_q, scan_idx_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  logic [6:0]        seg_q, seg_d, seg_raw;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] sel_q, sel_d, sel_raw;
  logic              lead_zero, blank;

  always_comb begin
    // Walk from the top digit down; the selected digit blanks only if all above it are zero too.
    lead_zero = 1'b1;
    blank     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero & (digit_q[i] == 4'd0);
      if (i == int'(scan_idx_q)) begin
        blank = lead_zero && (i != 0);
      end
    end
    seg_raw = (blank_lz && blank) ? 7'b0 : seg_decode(digit_q[scan_idx_q]);
    sel_raw = '0;
    sel_raw[scan_idx_q] = 1'b1;
    seg_d = seg_raw ^ {7{SEG_ACT_LOW}};
    dp_d  = (scan_idx_q == '0) ^ SEG_ACT_LOW;
    sel_d = sel_raw ^ {DIGITS{SEL_ACT_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
      seg_q      <= {7{SEG_ACT_LOW}};
      dp_q       <= SEG_ACT_LOW;
      sel_q      <= {DIGITS{SEL_ACT_LOW}};
    end else begin
      wrap_q <= wrap_d;
      if (ena) begin
        pre_q      <= pre_d;
        scan_cnt_q <= scan_cnt_d;
        scan_idx_q <= scan_idx_d;
        seg_q      <= seg_d;
        dp_q       <= dp_d;
        sel_q      <= sel_d;
      end
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = sel_q;

endmodule
